ysyx_041461_clint_mh: RTL and testbench



---
 rtl/ysyx_041461_clint_mh_pkg.sv | 31 +++
 rtl/ysyx_041461_clint_decode.sv | 32 +++
 rtl/ysyx_041461_clint_mh.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_041461_clint_mh.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_clint_mh_pkg.sv
// Shared definitions for the multi-hart CLINT: FSM states, register offsets,
// AXI response codes and the byte-strobe merge helper.
package ysyx_041461_clint_mh_pkg;

  typedef enum logic [1:0] {
    ysyx_041461_CLINTMH_IDLE  = 2'd0,
    ysyx_041461_CLINTMH_WDATA = 2'd1,
    ysyx_041461_CLINTMH_WRESP = 2'd2,
    ysyx_041461_CLINTMH_RDATA = 2'd3
  } clint_state_t;

  localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // Bytes with their strobe set take the new value, the rest keep the old one.
  function automatic logic [63:0] merge64(input logic [63:0] old_v,
                                          input logic [63:0] new_v,
                                          input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/ysyx_041461_clint_decode.sv
// Address decoder: maps a bus address to one CLINT register and hart index,
// flagging unmapped addresses and bursts as errors.
module ysyx_041461_clint_decode
  import ysyx_041461_clint_mh_pkg::*;
#(
  parameter int          NHART = 1,
  parameter logic [31:0] BASE  = 32'h0200_0000
) (
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        o_hit_msip,
  output logic        o_hit_cmp,
  output logic        o_hit_mtime,
  output logic [2:0]  o_hart,
  output logic        o_err
);

  logic [31:0] w_off, w_moff, w_coff;

  // Offsets below a window wrap to huge values, so a single upper-bound
  // compare also rejects addresses underneath it.
  assign w_off  = i_addr - BASE;
  assign w_moff = w_off - MSIP_OFF;
  assign w_coff = w_off - MTIMECMP_OFF;

  assign o_hit_msip  = (w_moff >> 2) < 32'(NHART);
  assign o_hit_cmp   = (w_coff >> 3) < 32'(NHART);
  assign o_hit_mtime = (w_off >> 3) == (MTIME_OFF >> 3);
  assign o_hart      = o_hit_msip ? w_moff[4:2] : w_coff[5:3];
  assign o_err       = !(o_hit_msip || o_hit_cmp || o_hit_mtime) || (i_len != 8'd0);

endmodule

// File: rtl/ysyx_041461_clint_mh.sv
// Multi-hart CLINT on an AXI4 slave port: shared prescaled mtime, per-hart
// mtimecmp and msip, SLVERR for unmapped or burst accesses.
module ysyx_041461_clint_mh
  import ysyx_041461_clint_mh_pkg::*;
#(
  parameter int          NHART    = 1,
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          TICK_DIV = 1,
  parameter int          ID_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CLINT_awvalid,
  input  logic [ID_W-1:0]   CLINT_awid,
  input  logic [31:0]       CLINT_awaddr,
  input  logic [7:0]        CLINT_awlen,
  input  logic [2:0]        CLINT_awsize,
  input  logic [1:0]        CLINT_awburst,
  output logic              CLINT_awready,
  input  logic              CLINT_wvalid,
  input  logic [63:0]       CLINT_wdata,
  input  logic [7:0]        CLINT_wstrb,
  input  logic              CLINT_wlast,
  output logic              CLINT_wready,
  output logic              CLINT_bvalid,
  output logic [ID_W-1:0]   CLINT_bid,
  output logic [1:0]        CLINT_bresp,
  input  logic              CLINT_bready,
  input  logic              CLINT_arvalid,
  input  logic [ID_W-1:0]   CLINT_arid,
  input  logic [31:0]       CLINT_araddr,
  input  logic [7:0]        CLINT_arlen,
  input  logic [2:0]        CLINT_arsize,
  input  logic [1:0]        CLINT_arburst,
  output logic              CLINT_arready,
  output logic              CLINT_rvalid,
  output logic [ID_W-1:0]   CLINT_rid,
  output logic [1:0]        CLINT_rresp,
  output logic [63:0]       CLINT_rdata,
  output logic              CLINT_rlast,
  input  logic              CLINT_rready,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip,
  output logic [63:0]       mtime_o
);

  clint_state_t            r_state;
  logic [ID_W-1:0]         r_id;
  logic [7:0]              r_len, r_beat;
  logic                    r_err, r_lane;
  logic                    r_hit_msip, r_hit_cmp, r_hit_mt;
  logic [2:0]              r_hart;
  logic [63:0]             r_rdata;
  logic [31:0]             r_presc;
  logic [63:0]             r_mtime;
  logic [NHART-1:0][63:0]  r_cmp;
  logic [NHART-1:0]        r_msip;

  logic       w_aw_msip, w_aw_cmp, w_aw_mt, w_aw_err;
  logic       w_ar_msip, w_ar_cmp, w_ar_mt, w_ar_err;
  logic [2:0] w_aw_hart, w_ar_hart;
  logic       w_tick, w_wen, w_msip_strb, w_msip_bit;
  logic [63:0] w_snap;
  logic       w_unused;

  // Size and burst type carry no information here: only single 64-bit beats are honoured.
  assign w_unused = ^{CLINT_awsize, CLINT_awburst, CLINT_arsize, CLINT_arburst};

  ysyx_041461_clint_decode #(.NHART(NHART), .BASE(BASE)) u_dec_aw (
    .i_addr(CLINT_awaddr), .i_len(CLINT_awlen),
    .o_hit_msip(w_aw_msip), .o_hit_cmp(w_aw_cmp), .o_hit_mtime(w_aw_mt),
    .o_hart(w_aw_hart), .o_err(w_aw_err)
  );

  ysyx_041461_clint_decode #(.NHART(NHART), .BASE(BASE)) u_dec_ar (
    .i_addr(CLINT_araddr), .i_len(CLINT_arlen),
    .o_hit_msip(w_ar_msip), .o_hit_cmp(w_ar_cmp), .o_hit_mtime(w_ar_mt),
    .o_hart(w_ar_hart), .o_err(w_ar_err)
  );

  assign w_tick      = (r_presc == 32'(TICK_DIV - 1));
  assign w_wen       = (r_state == ysyx_041461_CLINTMH_WDATA) && CLINT_wvalid && !r_err;
  assign w_msip_strb = r_lane ? CLINT_wstrb[4] : CLINT_wstrb[0];
  assign w_msip_bit  = r_lane ? CLINT_wdata[32] : CLINT_wdata[0];

  always_comb begin
    w_snap = '0;
    if (!w_ar_err) begin
      if (w_ar_mt) w_snap = r_mtime;
      for (int h = 0; h < NHART; h++) begin
        if (w_ar_hart == h[2:0]) begin
          if (w_ar_cmp)  w_snap = r_cmp[h];
          if (w_ar_msip) w_snap = {31'b0, r_msip[h], 31'b0, r_msip[h]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ysyx_041461_CLINTMH_IDLE;
      r_id       <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_err      <= 1'b0;
      r_lane     <= 1'b0;
      r_hit_msip <= 1'b0;
      r_hit_cmp  <= 1'b0;
      r_hit_mt   <= 1'b0;
      r_hart     <= '0;
      r_rdata    <= '0;
      r_presc    <= '0;
      r_mtime    <= '0;
      r_cmp      <= '1;
      r_msip     <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 32'd1;
      // A software write to mtime suppresses that cycle's increment.
      if (w_wen && r_hit_mt) r_mtime <= merge64(r_mtime, CLINT_wdata, CLINT_wstrb);
      else if (w_tick)       r_mtime <= r_mtime + 64'd1;

      for (int h = 0; h < NHART; h++) begin
        if (w_wen && r_hit_cmp && r_hart == h[2:0])
          r_cmp[h] <= merge64(r_cmp[h], CLINT_wdata, CLINT_wstrb);
        if (w_wen && r_hit_msip && r_hart == h[2:0] && w_msip_strb)
          r_msip[h] <= w_msip_bit;
      end

      unique case (r_state)
        ysyx_041461_CLINTMH_IDLE: begin
          if (CLINT_awvalid) begin
            r_id       <= CLINT_awid;
            r_len      <= CLINT_awlen;
            r_err      <= w_aw_err;
            r_lane     <= CLINT_awaddr[2];
            r_hit_msip <= w_aw_msip;
            r_hit_cmp  <= w_aw_cmp;
            r_hit_mt   <= w_aw_mt;
            r_hart     <= w_aw_hart;
            r_state    <= ysyx_041461_CLINTMH_WDATA;
          end else if (CLINT_arvalid) begin
            r_id    <= CLINT_arid;
            r_len   <= CLINT_arlen;
            r_err   <= w_ar_err;
            r_rdata <= w_snap;
            r_beat  <= '0;
            r_state <= ysyx_041461_CLINTMH_RDATA;
          end
        end
        ysyx_041461_CLINTMH_WDATA:
          if (CLINT_wvalid && CLINT_wlast) r_state <= ysyx_041461_CLINTMH_WRESP;
        ysyx_041461_CLINTMH_WRESP:
          if (CLINT_bready) r_state <= ysyx_041461_CLINTMH_IDLE;
        ysyx_041461_CLINTMH_RDATA:
          if (CLINT_rready) begin
            if (r_beat == r_len) r_state <= ysyx_041461_CLINTMH_IDLE;
            else                 r_beat  <= r_beat + 8'd1;
          end
        default: r_state <= ysyx_041461_CLINTMH_IDLE;
      endcase
    end
  end

  assign CLINT_awready = (r_state == ysyx_041461_CLINTMH_IDLE);
  assign CLINT_arready = (r_state == ysyx_041461_CLINTMH_IDLE) && !CLINT_awvalid;
  assign CLINT_wready  = (r_state == ysyx_041461_CLINTMH_WDATA);
  assign CLINT_bvalid  = (r_state == ysyx_041461_CLINTMH_WRESP);
  assign CLINT_bid     = r_id;
  assign CLINT_bresp   = r_err ? AXI_SLVERR : AXI_OKAY;
  assign CLINT_rvalid  = (r_state == ysyx_041461_CLINTMH_RDATA);
  assign CLINT_rid     = r_id;
  assign CLINT_rresp   = r_err ? AXI_SLVERR : AXI_OKAY;
  assign CLINT_rdata   = r_rdata;
  assign CLINT_rlast   = CLINT_rvalid && (r_beat == r_len);

  always_comb begin
    mtip = '0;
    for (int h = 0; h < NHART; h++) mtip[h] = (r_mtime >= r_cmp[h]);
  end

  assign msip    = r_msip;
  assign mtime_o = r_mtime;

endmodule

// File: tb/tb_ysyx_041461_clint_mh.sv
// Randomized bench for the multi-hart CLINT against a cycle-level register model.
module tb_ysyx_041461_clint_mh;

  localparam int NH  = 2;
  localparam int TD  = 3;
  localparam int LIM = 40;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [3:0] awid = 0, arid = 0;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [7:0] awlen = 0, arlen = 0, wstrb = 0;
  logic [2:0] awsize = 3'd3, arsize = 3'd3;
  logic [1:0] awburst = 2'd1, arburst = 2'd1;
  logic [63:0] wdata = 0;
  logic awready, arready, wready, bvalid, rvalid, rlast;
  logic [3:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [63:0] rdata, mtime_o;
  logic [NH-1:0] mtip, msip;

  ysyx_041461_clint_mh #(.NHART(NH), .BASE(BASE), .TICK_DIV(TD), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .CLINT_awvalid(awvalid), .CLINT_awid(awid), .CLINT_awaddr(awaddr), .CLINT_awlen(awlen),
    .CLINT_awsize(awsize), .CLINT_awburst(awburst), .CLINT_awready(awready),
    .CLINT_wvalid(wvalid), .CLINT_wdata(wdata), .CLINT_wstrb(wstrb), .CLINT_wlast(wlast),
    .CLINT_wready(wready),
    .CLINT_bvalid(bvalid), .CLINT_bid(bid), .CLINT_bresp(bresp), .CLINT_bready(bready),
    .CLINT_arvalid(arvalid), .CLINT_arid(arid), .CLINT_araddr(araddr), .CLINT_arlen(arlen),
    .CLINT_arsize(arsize), .CLINT_arburst(arburst), .CLINT_arready(arready),
    .CLINT_rvalid(rvalid), .CLINT_rid(rid), .CLINT_rresp(rresp), .CLINT_rdata(rdata),
    .CLINT_rlast(rlast), .CLINT_rready(rready),
    .mtip(mtip), .msip(msip), .mtime_o(mtime_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input int n);
    total++;
    if (n >= LIM) begin
      bad++;
      $display("FAIL %s: timed out after %0d cycles, want handshake", nm, n);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [NH];
  logic [NH-1:0] m_msip;
  int m_edge;            // clock edges since reset was released
  bit pw_v = 0, pw_err;
  logic [31:0] pw_addr;
  logic [63:0] pw_data;
  logic [7:0]  pw_strb;

  // 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic int kind(input logic [31:0] a, output int h);
    logic [31:0] off;
    off = a - BASE;
    h = 0;
    if (off < 32'(4 * NH)) begin h = int'(off / 4); return 1; end
    if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * NH)) begin h = int'((off - 32'h4000) / 8); return 2; end
    if (off >= 32'hBFF8 && off <= 32'hBFFF) return 3;
    return 0;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [7:0] len);
    int h;
    return (kind(a, h) == 0) || (len != 0);
  endfunction

  function automatic logic [63:0] mdl_read(input logic [31:0] a, input logic [7:0] len);
    int h, k;
    k = kind(a, h);
    if (len != 0) return 64'd0;
    case (k)
      1: return {31'd0, m_msip[h], 31'd0, m_msip[h]};
      2: return m_cmp[h];
      3: return m_mtime;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] bytes(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = s[i / 8] ? n[i] : o[i];
    return r;
  endfunction

  always @(posedge clk) begin
    int h, k;
    bit tick, wrote;
    if (!rst_n) begin
      m_mtime = 0; m_msip = 0; m_edge = 0; pw_v = 0;
      for (int i = 0; i < NH; i++) m_cmp[i] = '1;
    end else begin
      tick = (m_edge % TD) == TD - 1;
      m_edge++;
      wrote = 0;
      if (pw_v && !pw_err) begin
        k = kind(pw_addr, h);
        if (k == 1 && pw_strb[pw_addr[2] ? 4 : 0]) m_msip[h] = pw_data[pw_addr[2] ? 32 : 0];
        if (k == 2) m_cmp[h] = bytes(m_cmp[h], pw_data, pw_strb);
        if (k == 3) begin m_mtime = bytes(m_mtime, pw_data, pw_strb); wrote = 1; end
      end
      pw_v = 0;
      if (tick && !wrote) m_mtime = m_mtime + 64'd1;
    end
  end

  // Continuous comparison of the interrupt lines and mtime.
  always @(negedge clk) begin
    logic [NH-1:0] em;
    if (chk_on) begin
      for (int i = 0; i < NH; i++) em[i] = (m_mtime >= m_cmp[i]);
      chk("mtime_o", mtime_o, m_mtime);
      chk("mtip", 64'(mtip), 64'(em));
      chk("msip", 64'(msip), 64'(m_msip));
    end
  end

  // ---------------- bus tasks ----------------
  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    awvalid = 1; awaddr = a; awlen = len; awid = id;
    while (!awready && n < LIM) begin step(); n++; end
    tmo("aw_wait", n);
    step();
    awvalid = 0;
  endtask

  task automatic w_phase(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                         input logic [7:0] len, input bit align);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (align && (m_edge % TD) != TD - 1 && n < LIM) begin step(); n++; end
      wvalid = 1; wdata = d; wstrb = s; wlast = (b == int'(len));
      while (!wready && n < LIM) begin step(); n++; end
      tmo("w_wait", n);
      pw_addr = a; pw_data = d; pw_strb = s; pw_err = is_err(a, len); pw_v = 1;
      step();
    end
    wvalid = 0; wlast = 0;
  endtask

  task automatic b_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                         output logic [1:0] rs);
    int n = 0;
    bready = 1;
    while (!bvalid && n < LIM) begin step(); n++; end
    tmo("b_wait", n);
    chk("bresp", bresp, is_err(a, len) ? 2'b10 : 2'b00);
    chk("bid", bid, id);
    rs = bresp;
    step();
    bready = 0;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                          output logic [63:0] ed);
    int n = 0;
    arvalid = 1; araddr = a; arlen = len; arid = id;
    while (!arready && n < LIM) begin step(); n++; end
    tmo("ar_wait", n);
    ed = mdl_read(a, len);
    step();
    arvalid = 0;
  endtask

  task automatic r_phase(input logic [63:0] ed, input bit ee, input logic [7:0] len,
                         input logic [3:0] id, input int hold,
                         output logic [63:0] got, output int nb, output logic [1:0] rs);
    int n;
    got = '0; nb = 0; rs = '0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < LIM) begin step(); n++; end
      tmo("r_wait", n);
      for (int k = 0; k < hold; k++) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, ed);
        step();
      end
      rready = 1;
      chk("rdata", rdata, ed);
      chk("rresp", rresp, ee ? 2'b10 : 2'b00);
      chk("rid", rid, id);
      chk("rlast", rlast, b == int'(len));
      if (b == 0) got = rdata;
      if (rlast) nb = b + 1;
      rs = rresp;
      step();
      rready = 0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                    input logic [7:0] len, input logic [3:0] id, input bit align,
                    output logic [1:0] rs);
    aw_phase(a, len, id);
    w_phase(a, d, s, len, align);
    b_phase(a, len, id, rs);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                    input int hold, output logic [63:0] got, output int nb, output logic [1:0] rs);
    logic [63:0] ed;
    ar_phase(a, len, id, ed);
    r_phase(ed, is_err(a, len), len, id, hold, got, nb, rs);
  endtask

  logic [31:0] atab [10] = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008, 32'h0200_4000,
                             32'h0200_4008, 32'h0200_4010, 32'h0200_BFF8, 32'h0200_BFFC,
                             32'h0200_8000, 32'h0300_0000};

  initial begin
    logic [1:0] rs;
    logic [63:0] got, ed;
    int nb, n;

    // Reset state
    repeat (3) step();
    chk("rst_awready", awready, 1); chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);         chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_mtime", mtime_o, 0);   chk("rst_mtip", mtip, 0);
    chk("rst_msip", msip, 0);
    rst_n = 1; chk_on = 1;

    // Prescaler: 9 clocks at divide-by-3
    repeat (9) step();
    chk("presc_mtime", mtime_o, 64'd3);
    chk("presc_mtip", mtip, 0);

    // Timer interrupt on hart 1
    wr(32'h0200_4008, 64'h10, 8'hFF, 0, 4'h3, 0, rs);
    chk("cmp1_bresp", rs, 2'b00);
    n = 0;
    while (m_mtime != 64'h10 && n < 200) begin step(); n++; end
    chk("mtip1_rise", mtip, 2'b10);

    // Software interrupt on hart 1 via the upper lane
    wr(32'h0200_0004, 64'h0000_0001_0000_0000, 8'hF0, 0, 4'h5, 0, rs);
    chk("msip_val", msip, 2'b10);
    rd(32'h0200_0004, 0, 4'h6, 0, got, nb, rs);
    chk("msip_rd", got, 64'h0000_0001_0000_0001);

    // Error responses
    rd(32'h0200_BFF8, 8'd3, 4'h7, 0, got, nb, rs);
    chk("burst_beats", nb, 4);
    chk("burst_resp", rs, 2'b10);
    rd(32'h0200_0100, 0, 4'h8, 0, got, nb, rs);
    chk("unmapped_resp", rs, 2'b10);
    chk("unmapped_beats", nb, 1);

    // mtime write landing on a tick, then wrap on the next tick
    aw_phase(32'h0200_BFF8, 0, 4'h9);
    w_phase(32'h0200_BFF8, '1, 8'hFF, 0, 1);
    chk("mtime_wr_tick", mtime_o, '1);
    b_phase(32'h0200_BFF8, 0, 4'h9, rs);
    ar_phase(32'h0200_BFF8, 0, 4'hA, ed);
    step();
    chk("mtime_wrap", mtime_o, 64'd0);
    r_phase(ed, 0, 0, 4'hA, 4, got, nb, rs);
    chk("mtime_rd_ones", got, '1);

    // Reset while the write response is pending
    aw_phase(32'h0200_4000, 0, 4'hB);
    w_phase(32'h0200_4000, 64'h5, 8'hFF, 0, 0);
    n = 0;
    while (!bvalid && n < LIM) begin step(); n++; end
    tmo("bvalid_before_rst", n);
    rst_n = 0;
    step();
    chk("rst_mid_bvalid", bvalid, 0);
    rst_n = 1;
    step();
    rd(32'h0200_4000, 0, 4'hC, 0, got, nb, rs);
    chk("rst_mid_cmp0", got, '1);

    // Simultaneous aw/ar: the write goes first
    awvalid = 1; awaddr = 32'h0200_4008; awlen = 0; awid = 4'hD;
    arvalid = 1; araddr = 32'h0200_4008; arlen = 0; arid = 4'hE;
    #1;
    chk("prio_awready", awready, 1);
    chk("prio_arready", arready, 0);
    step();
    awvalid = 0;
    chk("prio_ar_blocked", arready, 0);
    w_phase(32'h0200_4008, 64'h77, 8'hFF, 0, 0);
    b_phase(32'h0200_4008, 0, 4'hD, rs);
    ar_phase(32'h0200_4008, 0, 4'hE, ed);
    r_phase(ed, 0, 0, 4'hE, 0, got, nb, rs);
    chk("prio_rd", got, 64'h77);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [7:0] len;
      logic [63:0] d;
      a   = atab[$urandom_range(0, 9)];
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
      d   = $urandom_range(0, 1) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom};
      if ($urandom_range(0, 1))
        wr(a, d, 8'($urandom), len, 4'($urandom), 0, rs);
      else
        rd(a, len, 4'($urandom), $urandom_range(0, 2), got, nb, rs);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
